// File: rtl/reciprocal_seq.sv
// Multi-cycle signed Q(M.N) reciprocal: normalise |x| with a leading-zero count,
// then a bit-serial restoring divide of 2^(2W-1) by the normalised operand.

module lzc #(
  parameter int WIDTH = 32,
  parameter int CW    = $clog2(WIDTH) + 1
) (
  input  logic [WIDTH-1:0] i_data,
  output logic [CW-1:0]    o_count
);
  // Scan upward so the highest set bit has the final say; all-zero yields WIDTH.
  always_comb begin
    o_count = CW'(WIDTH);
    for (int i = 0; i < WIDTH; i++) begin
      if (i_data[i]) o_count = CW'(WIDTH - 1 - i);
    end
  end
endmodule

// state | meaning
// IDLE  | in_ready high, waiting for an operand
// NORM  | register |x| normalised and its lz count, seed the divider
// DIV   | W+1 restoring-division steps, one quotient bit per cycle
// FIX   | scale quotient back, apply sign and saturation
// DONE  | result held on out_data until out_ready
module reciprocal_seq #(
  parameter int M = 12,
  parameter int N = 12
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [M+N-1:0]   in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [M+N-1:0]   out_data,
  output logic             out_sat,
  output logic             busy
);
  localparam int W   = M + N;
  localparam int LZW = 6;
  localparam int CW  = $clog2(W + 1);
  localparam logic [W:0] REM_INIT = (W+1)'(1) << (W - 2);
  localparam logic [W:0] MINMAG   = (W+1)'(1) << (W - 1);
  localparam logic [W:0] MAXP     = MINMAG - (W+1)'(1);

  typedef enum logic [2:0] {IDLE, NORM, DIV, FIX, DONE} state_t;

  state_t         r_state;
  logic [W-1:0]   r_x;
  logic           r_neg;
  logic           r_zero;
  logic [W-1:0]   r_d;
  logic [LZW-1:0] r_lz;
  logic [W:0]     r_rem;
  logic [W:0]     r_q;
  logic [CW-1:0]  r_cnt;
  logic           r_in_ready;
  logic           r_busy;
  logic           r_out_valid;
  logic [W-1:0]   r_out_data;
  logic           r_out_sat;

  logic [W-1:0]   w_ax;
  logic [31:0]    w_lzc_in;
  logic [LZW-1:0] w_lz;
  logic [W-1:0]   w_d;
  logic [W:0]     w_rem_sh;
  logic           w_ge;
  logic [W:0]     w_rem_nxt;
  logic [LZW-1:0] w_shamt;
  logic [W:0]     w_mag;
  logic [W-1:0]   w_res;
  logic           w_sat;

  // Two's-complement negate of the most negative code wraps to 2^(W-1), which is the right magnitude.
  assign w_ax     = r_neg ? (W'(0) - r_x) : r_x;
  assign w_lzc_in = 32'(w_ax) << (32 - W);

  lzc #(.WIDTH(32), .CW(LZW)) u_lzc (
    .i_data  (w_lzc_in),
    .o_count (w_lz)
  );

  assign w_d       = w_ax << w_lz;
  assign w_rem_sh  = r_rem << 1;
  assign w_ge      = (w_rem_sh >= {1'b0, r_d});
  assign w_rem_nxt = w_ge ? (w_rem_sh - {1'b0, r_d}) : w_rem_sh;

  // Quotient is 2^(2W-1)/(ax<<lz); shifting by (2M-1-lz) rescales it to 2^(2N)/ax.
  assign w_shamt = LZW'(2 * M - 1) - r_lz;
  assign w_mag   = r_q >> w_shamt;

  always_comb begin
    w_res = '0;
    w_sat = 1'b0;
    if (r_zero) begin
      w_res = MAXP[W-1:0];
      w_sat = 1'b1;
    end else if (!r_neg) begin
      if (w_mag > MAXP) begin
        w_res = MAXP[W-1:0];
        w_sat = 1'b1;
      end else begin
        w_res = w_mag[W-1:0];
      end
    end else begin
      if (w_mag > MINMAG) begin
        w_res = MINMAG[W-1:0];
        w_sat = 1'b1;
      end else begin
        w_res = W'(0) - w_mag[W-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_x         <= '0;
      r_neg       <= 1'b0;
      r_zero      <= 1'b0;
      r_d         <= '0;
      r_lz        <= '0;
      r_rem       <= '0;
      r_q         <= '0;
      r_cnt       <= '0;
      r_in_ready  <= 1'b1;
      r_busy      <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_sat   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_x        <= in_data;
            r_neg      <= in_data[W-1];
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= NORM;
          end
        end
        NORM: begin
          r_d     <= w_d;
          r_lz    <= w_lz;
          r_zero  <= (w_ax == '0);
          r_rem   <= REM_INIT;
          r_q     <= '0;
          r_cnt   <= CW'(W);
          r_state <= DIV;
        end
        DIV: begin
          r_rem <= w_rem_nxt;
          r_q   <= {r_q[W-1:0], w_ge};
          if (r_cnt == '0) r_state <= FIX;
          else             r_cnt   <= r_cnt - CW'(1);
        end
        FIX: begin
          r_out_data  <= w_res;
          r_out_sat   <= w_sat;
          r_out_valid <= 1'b1;
          r_state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign busy      = r_busy;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_sat   = r_out_sat;
endmodule

// File: doc/reciprocal_seq.md
# reciprocal_seq

Multi-cycle signed fixed-point reciprocal unit, result = 1/x in the same Q(M.N) format as the input. It sits downstream of the `lzc` leading-zero counter and instantiates it with WIDTH=32. The LZC count normalises the operand magnitude ahead of a bit-serial restoring divider. It serves the raycaster's per-column distance and step math through a valid/ready handshake on each side.

## Interface
- `M`, default 12, integer bits of input and output (including sign).
- `N`, default 12, fractional bits. Constraints: N ≤ M and W = M+N ≤ 32.
- `clk`  in  1  sole clock; all state changes on its rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  operand present.
- `in_ready`  out  1  high only in IDLE; a transfer occurs on the edge where `in_valid & in_ready`.
- `in_data`  in  W  signed Q(M.N) operand x.
- `out_valid`  out  1  result present; held until accepted.
- `out_ready`  in  1  consumer accepts the result on the edge where `out_valid & out_ready`.
- `out_data`  out  W  signed Q(M.N) reciprocal.
- `out_sat`  out  1  result was saturated; also set for x = 0.
- `busy`  out  1  high in every state except IDLE.

## Operation
- **Arithmetic (W=24, N=12 example):**
  - ax = |x| as W-bit unsigned; x = −2^(W−1) gives ax = 2^(W−1).
  - lz = lzc({ax, (32−W) zeros}). The range is 0..W−1 for nonzero ax.
  - d = ax << lz, a W-bit value with MSB set.
  - q = floor(2^(2W−1) / d), a W+1-bit value.
  - mag = q >> (2W−1−2N−lz). This equals floor(2^(2N)/ax), truncated toward zero.
- **Sign and saturation:**
  - Positive x: if mag > 2^(W−1)−1, then out_data = 2^(W−1)−1 and out_sat = 1.
  - Negative x: if mag > 2^(W−1), then out_data = −2^(W−1) and out_sat = 1. Otherwise out_data = −mag. mag = 2^(W−1) exactly is not saturated.
  - x = 0: out_data = 2^(W−1)−1 and out_sat = 1. The pipeline still runs full length, and the divider result is discarded.
- **FSM states:**
  - IDLE: in_ready = 1. On accept, register x and its sign, then go to NORM.
  - NORM: register d and lz in one cycle, initialise the divider, then go to DIV.
  - DIV: restoring division, one quotient bit per cycle, MSB first, W+1 cycles. Then go to FIX.
  - FIX: shift, saturate and negate. Register out_data and out_sat, then go to DONE.
  - DONE: out_valid = 1. On `out_ready`, go to IDLE.
- in_valid is ignored outside IDLE. There is no overlap of operations and no input buffering.
- out_data and out_sat stay stable from DONE entry until accepted. After acceptance they keep their last value; they are not cleared.

## Timing
- On reset assertion (asynchronous, any state, including mid-DIV): state = IDLE. All outputs go to 0 (in_ready rises to 1 since state is IDLE), and the in-flight operation is dropped.
- On the first edge after reset_n deasserts, the block is ready to accept.
- Latency is fixed and independent of the operand, zero included.
  - Accept at edge 0 → NORM.
  - Edge 1 → DIV.
  - Edges 2..W+2 are the division steps.
  - Edge W+3 → DONE. out_valid is high after edge W+3, which is 27 cycles for W=24.
- If out_ready is already high on DONE entry, the result is accepted on the next edge. IDLE is re-entered, and a new operand can be accepted on the edge after that.
  - Minimum issue interval: W+5 edges (29).
- in_ready falls on the accept edge and stays low until IDLE is re-entered.
- out_valid falls on the edge where `out_valid & out_ready`.
- busy is the complement of in_ready.

## Test plan
- Exact powers of two:
  - 0x001000 (1.0) → 0x001000.
  - 0x002000 (2.0) → 0x000800.
  - 0xFFF000 (−1.0) → 0xFFF000.
  - All with out_sat = 0 and out_valid exactly 27 cycles after accept.
- Truncation toward zero:
  - 0x003000 (3.0) → 0x000555.
  - 0xFFD000 (−3.0) → 0xFFFAAB.
  - 0x000003 → 0x555555.
  - 0x7FFFFF → 0x000002.
  - 0x800000 → 0xFFFFFE.
- Saturation:
  - 0x000000 → 0x7FFFFF with sat = 1.
  - 0x000001 → 0x7FFFFF with sat = 1.
  - 0x000002 → 0x7FFFFF with sat = 1.
  - 0xFFFFFF → 0x800000 with sat = 1.
  - 0xFFFFFE → 0x800000 with sat = 0.
- Backpressure:
  - Hold out_ready low for 10 cycles after out_valid: out_data stays stable and out_valid stays high.
  - in_valid pulses during busy are ignored.
  - Release out_ready: one transfer occurs, then in_ready returns the following cycle.
- Reset mid-operation:
  - Assert reset_n low at DIV cycle 10: outputs go to 0 immediately (asynchronously) and in_ready goes to 1.
  - After release, operand 0x002000 → 0x000800 with no residue from the aborted operation.
- Random sweep: 10k random signed operands with random out_ready throttling, compared against the floor(2^24/|x|) reference model with the sign and saturation rules above.
